// File: rtl/clock_freq_meter.sv
// Measures a slow asynchronous signal against the reference clock: rising edges per gate
// window, reference cycles between rising edges, and a loss-of-signal flag.
module clock_freq_meter #(
   parameter int unsigned GATE_CYCLES    = 50_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
   parameter int unsigned CNT_W          = 16,
   parameter int unsigned PER_W          = 32,
   parameter int unsigned SYNC_STAGES    = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sig_in,
   output logic [CNT_W-1:0] freq_count,
   output logic             freq_valid,
   output logic             freq_ovf,
   output logic [PER_W-1:0] period_cycles,
   output logic             period_valid,
   output logic             sig_lost
);

   localparam int unsigned GATE_W = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
   localparam int unsigned ARM_W  = $clog2(SYNC_STAGES + 2);

   localparam logic [GATE_W-1:0] GateLast   = GATE_W'(GATE_CYCLES - 1);
   localparam logic [ARM_W-1:0]  ArmDone    = ARM_W'(SYNC_STAGES + 1);
   localparam logic [PER_W-1:0]  TimeoutVal = PER_W'(TIMEOUT_CYCLES);
   // IDLE starts counting at 0 rather than 1, so it times out one count earlier.
   localparam logic [PER_W-1:0]  IdleLimit  = PER_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StMeasure = 2'd1;
   localparam logic [1:0] StLost    = 2'd2;

   // ---------------------------------------------------------------------------------------
   // Synchronizer, previous-value flop and rise-detect arming
   // ---------------------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic [ARM_W-1:0]       arm_q, arm_d;
   logic                   sync_out;
   logic                   armed;
   logic                   rise;

   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], sig_in};
      sync_out = sync_q[SYNC_STAGES-1];
      prev_d   = sync_out;
      armed    = (arm_q == ArmDone);
      arm_d    = armed ? arm_q : arm_q + ARM_W'(1);
      // Masked until the chain has flushed, so a level held through reset is not an edge.
      rise     = armed & sync_out & ~prev_q;
   end

   // ---------------------------------------------------------------------------------------
   // Frequency path: free-running gate window with saturating edge counter
   // ---------------------------------------------------------------------------------------
   logic [GATE_W-1:0] gate_q, gate_d;
   logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
   logic              win_ovf_q, win_ovf_d;
   logic [CNT_W-1:0]  freq_count_q, freq_count_d;
   logic              freq_ovf_q, freq_ovf_d;
   logic              freq_valid_q, freq_valid_d;
   logic              gate_term;
   logic              edge_at_max;
   logic [CNT_W-1:0]  edge_next;
   logic              ovf_next;

   always_comb begin
      gate_term   = (gate_q == GateLast);
      gate_d      = gate_term ? '0 : gate_q + GATE_W'(1);
      edge_at_max = &edge_cnt_q;
      edge_next   = edge_cnt_q + CNT_W'(rise & ~edge_at_max);
      ovf_next    = win_ovf_q | (rise & edge_at_max);

      edge_cnt_d   = edge_next;
      win_ovf_d    = ovf_next;
      freq_count_d = freq_count_q;
      freq_ovf_d   = freq_ovf_q;
      freq_valid_d = 1'b0;

      // An edge landing in the terminal cycle is folded into the closing window.
      if (gate_term) begin
         freq_count_d = edge_next;
         freq_ovf_d   = ovf_next;
         freq_valid_d = 1'b1;
         edge_cnt_d   = '0;
         win_ovf_d    = 1'b0;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Period path: IDLE / MEASURE / LOST
   // ---------------------------------------------------------------------------------------
   logic [1:0]       state_q, state_d;
   logic [PER_W-1:0] per_cnt_q, per_cnt_d;
   logic [PER_W-1:0] period_cycles_q, period_cycles_d;
   logic             period_valid_q, period_valid_d;
   logic             sig_lost_q, sig_lost_d;

   always_comb begin
      state_d         = state_q;
      per_cnt_d       = per_cnt_q;
      period_cycles_d = period_cycles_q;
      period_valid_d  = 1'b0;
      sig_lost_d      = sig_lost_q;

      case (state_q)
         StIdle: begin
            if (rise) begin
               state_d   = StMeasure;
               per_cnt_d = PER_W'(1);
            end else if (per_cnt_q == IdleLimit) begin
               state_d         = StLost;
               sig_lost_d      = 1'b1;
               period_cycles_d = '0;
               per_cnt_d       = '0;
            end else begin
               per_cnt_d = per_cnt_q + PER_W'(1);
            end
         end
         StMeasure: begin
            // A rise in the timeout cycle still completes a valid period.
            if (rise) begin
               period_cycles_d = per_cnt_q;
               period_valid_d  = 1'b1;
               per_cnt_d       = PER_W'(1);
            end else if (per_cnt_q == TimeoutVal) begin
               state_d         = StLost;
               sig_lost_d      = 1'b1;
               period_cycles_d = '0;
               per_cnt_d       = '0;
            end else begin
               per_cnt_d = per_cnt_q + PER_W'(1);
            end
         end
         StLost: begin
            if (rise) begin
               state_d    = StMeasure;
               sig_lost_d = 1'b0;
               per_cnt_d  = PER_W'(1);
            end
         end
         default: begin
            state_d   = StIdle;
            per_cnt_d = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q          <= '0;
         prev_q          <= 1'b0;
         arm_q           <= '0;
         gate_q          <= '0;
         edge_cnt_q      <= '0;
         win_ovf_q       <= 1'b0;
         freq_count_q    <= '0;
         freq_ovf_q      <= 1'b0;
         freq_valid_q    <= 1'b0;
         state_q         <= StIdle;
         per_cnt_q       <= '0;
         period_cycles_q <= '0;
         period_valid_q  <= 1'b0;
         sig_lost_q      <= 1'b0;
      end else begin
         sync_q          <= sync_d;
         prev_q          <= prev_d;
         arm_q           <= arm_d;
         gate_q          <= gate_d;
         edge_cnt_q      <= edge_cnt_d;
         win_ovf_q       <= win_ovf_d;
         freq_count_q    <= freq_count_d;
         freq_ovf_q      <= freq_ovf_d;
         freq_valid_q    <= freq_valid_d;
         state_q         <= state_d;
         per_cnt_q       <= per_cnt_d;
         period_cycles_q <= period_cycles_d;
         period_valid_q  <= period_valid_d;
         sig_lost_q      <= sig_lost_d;
      end
   end

   assign freq_count    = freq_count_q;
   assign freq_valid    = freq_valid_q;
   assign freq_ovf      = freq_ovf_q;
   assign period_cycles = period_cycles_q;
   assign period_valid  = period_valid_q;
   assign sig_lost      = sig_lost_q;

endmodule

// File: tb/tb_clock_freq_meter.sv
// Directed bench for clock_freq_meter: expected window/period results are queued as the
// stimulus is driven and popped when the matching valid pulse appears.
module tb_clock_freq_meter;

   localparam int GATE    = 100;
   localparam int TIMEOUT = 64;
   localparam int CNT_W   = 4;
   localparam int PER_W   = 8;

   logic             clk;
   logic             rst_n;
   logic             sig_in;
   logic [CNT_W-1:0] freq_count;
   logic             freq_valid;
   logic             freq_ovf;
   logic [PER_W-1:0] period_cycles;
   logic             period_valid;
   logic             sig_lost;

   int checks;
   int errors;

   // {ovf, count} per completed window, and period per reported edge.
   logic [CNT_W:0]   freq_q[$];
   logic [PER_W-1:0] per_q[$];

   clock_freq_meter #(
      .GATE_CYCLES   (GATE),
      .TIMEOUT_CYCLES(TIMEOUT),
      .CNT_W         (CNT_W),
      .PER_W         (PER_W),
      .SYNC_STAGES   (2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sig_in       (sig_in),
      .freq_count   (freq_count),
      .freq_valid   (freq_valid),
      .freq_ovf     (freq_ovf),
      .period_cycles(period_cycles),
      .period_valid (period_valid),
      .sig_lost     (sig_lost)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Scoreboard side: every valid pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (freq_valid === 1'b1) begin
            checks++;
            assert (freq_q.size() != 0) else begin
               errors++;
               $error("FAIL freq_valid_unexpected: got pulse count %0d expected none",
                      freq_count);
            end
            if (freq_q.size() != 0) begin
               logic [CNT_W:0] e;
               e = freq_q.pop_front();
               checks++;
               assert ({freq_ovf, freq_count} === e) else begin
                  errors++;
                  $error("FAIL freq_window: got ovf %0d count %0d expected ovf %0d count %0d",
                         freq_ovf, freq_count, e[CNT_W], e[CNT_W-1:0]);
               end
            end
         end
         if (period_valid === 1'b1) begin
            checks++;
            assert (per_q.size() != 0) else begin
               errors++;
               $error("FAIL period_valid_unexpected: got pulse period %0d expected none",
                      period_cycles);
            end
            if (per_q.size() != 0) begin
               logic [PER_W-1:0] p;
               p = per_q.pop_front();
               checks++;
               assert (period_cycles === p) else begin
                  errors++;
                  $error("FAIL period: got %0d expected %0d", period_cycles, p);
               end
            end
         end
      end
   end

   // Async assert off the clock edge, outputs checked before any clock; release on a
   // negedge, which becomes cycle 0 for the caller.
   task automatic do_reset();
      @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("rst_freq_count", 32'(freq_count), 0);
      chk("rst_freq_valid", 32'(freq_valid), 0);
      chk("rst_freq_ovf", 32'(freq_ovf), 0);
      chk("rst_period_cycles", 32'(period_cycles), 0);
      chk("rst_period_valid", 32'(period_valid), 0);
      chk("rst_sig_lost", 32'(sig_lost), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // n rising edges spaced per cycles; first_exp >= 0 queues a period for the first edge.
   task automatic square(input int per, input int n, input int first_exp);
      for (int i = 0; i < n; i++) begin
         sig_in = 1'b1;
         if (i == 0 && first_exp >= 0) per_q.push_back(PER_W'(first_exp));
         if (i > 0) per_q.push_back(PER_W'(per));
         cycles(per / 2);
         sig_in = 1'b0;
         cycles(per - per / 2);
      end
   endtask

   task automatic push_freq(input int cnt, input int ovf);
      freq_q.push_back({1'(ovf), CNT_W'(cnt)});
   endtask

   task automatic drain(input string tag, input int max_cycles);
      for (int i = 0; i < max_cycles && (freq_q.size() != 0 || per_q.size() != 0); i++)
         @(negedge clk);
      checks++;
      assert (freq_q.size() == 0 && per_q.size() == 0) else begin
         errors++;
         $error("FAIL %s_drain: got %0d freq and %0d period pending expected 0 and 0",
                tag, freq_q.size(), per_q.size());
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      sig_in = 1'b0;

      // 1: period-10 square wave, edges processed at cycles 5, 15, ..., 295.
      do_reset();
      push_freq(10, 0);
      push_freq(10, 0);
      push_freq(10, 0);
      cycles(2);
      square(10, 30, -1);
      chk("t1_sig_lost", 32'(sig_lost), 0);
      chk("t1_period", 32'(period_cycles), 10);
      drain("t1", 50);

      // 2: input held high through reset release is not an edge.
      sig_in = 1'b1;
      do_reset();
      push_freq(0, 0);
      cycles(63);
      chk("t2_lost_before", 32'(sig_lost), 0);
      cycles(1);
      chk("t2_lost_at_64", 32'(sig_lost), 1);
      chk("t2_period_zero", 32'(period_cycles), 0);
      drain("t2", 60);

      // 3: period-4 saturates two windows, then period-10 recovers.
      sig_in = 1'b0;
      do_reset();
      push_freq(15, 1);
      push_freq(15, 1);
      push_freq(11, 0);
      push_freq(10, 0);
      cycles(2);
      square(4, 50, -1);
      square(10, 20, 4);
      drain("t3", 20);

      // 4: loss after 64 idle cycles, recovery, period reported from the second new edge.
      do_reset();
      push_freq(5, 0);
      push_freq(3, 0);
      cycles(2);
      square(10, 5, -1);
      cycles(56);
      chk("t4_lost_before", 32'(sig_lost), 0);
      cycles(1);
      chk("t4_lost_set", 32'(sig_lost), 1);
      chk("t4_period_zero", 32'(period_cycles), 0);
      cycles(13);
      sig_in = 1'b1;
      cycles(2);
      chk("t4_lost_hold", 32'(sig_lost), 1);
      cycles(1);
      chk("t4_lost_clear", 32'(sig_lost), 0);
      chk("t4_period_still_zero", 32'(period_cycles), 0);
      cycles(2);
      sig_in = 1'b0;
      cycles(5);
      square(10, 2, 10);
      drain("t4", 100);

      // 5: single edge processed in the terminal gate cycle belongs to the ending window.
      do_reset();
      push_freq(1, 0);
      push_freq(0, 0);
      cycles(97);
      sig_in = 1'b1;
      cycles(2);
      chk("t5_lost_idle", 32'(sig_lost), 1);
      sig_in = 1'b0;
      cycles(1);
      chk("t5_lost_clear", 32'(sig_lost), 0);
      drain("t5", 120);

      // 6: reset mid-window and mid-period, then first window exactly 100 cycles later.
      do_reset();
      push_freq(10, 0);
      cycles(2);
      square(10, 15, -1);
      chk("t6_pre_count", 32'(freq_count), 10);
      chk("t6_pre_period", 32'(period_cycles), 10);
      do_reset();
      push_freq(0, 0);
      cycles(99);
      chk("t6_valid_early", 32'(freq_valid), 0);
      cycles(1);
      chk("t6_valid_at_100", 32'(freq_valid), 1);
      drain("t6", 10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
